reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Read-side companion to the general register file in the pipelined MIPS datapath.
- Tracks which GPRs have an outstanding write in flight and how many cycles remain until each result reaches the forwarding network.
- Decode (D) stage queries it for the two source registers (rs/rt):
  - it stalls D when an operand would be consumed before it exists;
  - otherwise it flags that the operand must come from forwarding, not from the register file.
- Writeback (W) retires entries.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width.
- TW, 2, width of the Tnew/Tuse countdown fields (max 3).
- OW, 2, width of the per-register outstanding-writer count (max 3 in flight).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous reset, active-low: entries clear on a rising clk edge while reset==0.
- flush  in  1  clear all entries next edge (pipeline flush).
- issue_valid  in  1  D stage presents a writing instruction.
- issue_wa  in  AW  destination register.
- issue_tnew  in  TW  cycles from issue until the result is forwardable.
- ra1  in  AW  source register 1 (rs).
- ra2  in  AW  source register 2 (rt).
- tuse1  in  TW  cycles until source 1 is consumed.
- tuse2  in  TW  cycles until source 2 is consumed.
- wb_en  in  1  W stage writes the GRF this cycle.
- wb_wa  in  AW  W stage destination.
- stall  out  1  combinational: hold D/F, bubble E.
- fwd1  out  1  source 1 pending but ready; select the forwarding path.
- fwd2  out  1  source 2 pending but ready; select the forwarding path.
- busy_count  out  AW+1  number of registers with owners!=0.
- ovf  out  1  sticky: issue attempted on a register with owners==3.

Behaviour:
- Per-register state: owners[OW], cnt[TW]. busy = (owners!=0). Register 0 is never busy.
- Reset (reset==0 at edge) or flush: all owners=0, cnt=0, ovf=0 (ovf cleared by reset only, not flush). After reset: stall=0, fwd1/fwd2=0, busy_count=0, ovf=0.
- Query, purely combinational, for k in {1,2}:
  - hazard_k = ra_k!=0 && busy[ra_k] && cnt[ra_k] > tuse_k.
  - fwd_k = ra_k!=0 && busy[ra_k] && !hazard_k.
  - stall = hazard_1 | hazard_2.
- Issue accept condition: accepted = issue_valid && !stall && issue_wa!=0. Not accepted → no state change for issue.
- Every edge, registered update for each register r, in priority order:
  1. Reset/flush.
  2. Issue to r: owners = owners + 1 - (wb to r ? 1 : 0); cnt = issue_tnew. The newest writer defines cnt.
  3. Otherwise, wb to r (wb_en && wb_wa==r && r!=0 && owners!=0): owners - 1; cnt decrements saturating at 0.
  4. Otherwise, if busy: cnt = cnt - 1, saturating at 0.
- Overflow: issue to r with owners==3 and no same-cycle wb to r → owners stays 3, cnt still loads, ovf set to 1.
- Underflow: wb to a non-busy register is ignored.
- busy_count: registered popcount of busy, updated the same edge as the state.
- Latency:
  - Issue is visible to the query on the cycle after acceptance.
  - wb clear is visible on the cycle after the wb edge.
  - Same-cycle issue/query on the same register is not bypassed. The D-stage instruction cannot depend on itself.
- stall must not depend on issue_valid; this prevents a combinational loop with acceptance.

Decomposition:
- Shared package (pipeline_defs): AW, NREG, TW, OW; Tuse/Tnew constants (TUSE_BRANCH=0, TUSE_ALU=1, TUSE_STORE=2, TNEW_ALU=1, TNEW_LOAD=2).
- One sub-module is natural: sb_entry. It holds owners/cnt for one register, with inputs issue_hit, wb_hit, clear. The top level instantiates NREG-1 copies (r1..r31) plus the query muxes and the popcount.

Test Plan:
- Reset: hold reset=0 two edges, then reset=1 → busy_count=0, stall=0, fwd1=fwd2=0, ovf=0.
- Load-use: issue wa=8, tnew=2. Next cycle ra1=8, tuse1=0 → stall=1. Cycle after that (cnt=1) still stall=1. Next cycle (cnt=0) → stall=0, fwd1=1.
- ALU forward: issue wa=9, tnew=1. Next cycle ra2=9, tuse2=1 → stall=0, fwd2=1. wb_en, wb_wa=9 → next cycle fwd2=0, busy_count=0.
- WAW: issue wa=4 tnew=2, then issue wa=4 tnew=1 → owners=2, cnt=1. First wb to 4 → still busy. Second wb → busy=0.
- Register 0 and ovf: issue wa=0 → busy_count unchanged, fwd=0. Four issues to wa=5 with no wb → ovf=1, stays 1 after flush, cleared by reset=0.
- Simultaneous: issue wa=6 while wb_wa=6 with owners=1 → owners=1, cnt=issue_tnew. Flush during stall → next cycle stall=0, busy_count=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline constants for the GPR scoreboard and its clients.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_scoreboard_pkg;

  localparam int AW   = 5;   // register address width
  localparam int NREG = 32;  // architectural registers
  localparam int TW   = 2;   // Tnew/Tuse countdown width
  localparam int OW   = 2;   // outstanding-writer count width

  // Cycles until an operand is consumed, counted from D.
  localparam logic [TW-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [TW-1:0] TUSE_ALU    = 2'd1;
  localparam logic [TW-1:0] TUSE_STORE  = 2'd2;

  // Cycles from issue until a result reaches the forwarding network.
  localparam logic [TW-1:0] TNEW_ALU    = 2'd1;
  localparam logic [TW-1:0] TNEW_LOAD   = 2'd2;

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One GPR's scoreboard slot: outstanding-writer count plus countdown to forwardable.
// Latency: issue/wb take effect on the next clk edge; busy_nxt_o exposes that next state.
// Backpressure: none; an issue to a full slot saturates the count and raises ovf_hit_o.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int TW_P = TW,
  parameter int OW_P = OW
) (
  input  logic            clk,
  input  logic            reset,       // synchronous, active-low
  input  logic            clear_i,     // pipeline flush
  input  logic            issue_hit_i, // accepted issue targets this register
  input  logic            wb_hit_i,    // W stage writes this register
  input  logic [TW_P-1:0] issue_tnew_i,
  output logic [TW_P-1:0] cnt_o,
  output logic            busy_o,
  output logic            busy_nxt_o,
  output logic            ovf_hit_o
);

  localparam logic [OW_P-1:0] OWN_MAX = '1;

  logic [OW_P-1:0] owners_q, owners_d;
  logic [TW_P-1:0] cnt_q, cnt_d;
  logic            wb_ok;

  function automatic logic [TW_P-1:0] sat_dec(input logic [TW_P-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // A wb to a register with no writer in flight is a stray retire and is dropped.
  assign wb_ok = wb_hit_i && (owners_q != '0);

  // Next-state: flush, then issue (newest writer owns cnt), then retire, then plain countdown.
  always_comb begin
    owners_d  = owners_q;
    cnt_d     = cnt_q;
    ovf_hit_o = 1'b0;
    if (clear_i) begin
      owners_d = '0;
      cnt_d    = '0;
    end else if (issue_hit_i) begin
      cnt_d = issue_tnew_i;
      if (wb_ok) begin
        owners_d = owners_q;           // one in, one out
      end else if (owners_q == OWN_MAX) begin
        ovf_hit_o = 1'b1;              // count saturates; top keeps the sticky flag
      end else begin
        owners_d = owners_q + 1'b1;
      end
    end else if (wb_ok) begin
      owners_d = owners_q - 1'b1;
      cnt_d    = sat_dec(cnt_q);
    end else if (owners_q != '0) begin
      cnt_d = sat_dec(cnt_q);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owners_q <= '0;
      cnt_q    <= '0;
    end else begin
      owners_q <= owners_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign busy_o     = (owners_q != '0);
  assign busy_nxt_o = (owners_d != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// GPR scoreboard: stalls D on a too-early operand, else flags operands that must be forwarded.
// Latency: query is combinational; issue/wb/flush are visible one cycle after their edge.
// Backpressure: stall holds D/F; an issue presented while stalled is not accepted.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,       // synchronous, active-low
  input  logic          flush,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_wa,
  input  logic [TW-1:0] issue_tnew,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [TW-1:0] tuse1,
  input  logic [TW-1:0] tuse2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_wa,
  output logic          stall,
  output logic          fwd1,
  output logic          fwd2,
  output logic [AW:0]   busy_count,
  output logic          ovf
);

  logic [NREG-1:0] busy_vec;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] ovf_hit_vec;
  logic [TW-1:0]   cnt_arr [NREG];
  logic            accepted;
  logic            hazard1, hazard2;
  logic [AW:0]     busy_count_q, busy_count_d;
  logic            ovf_q;

  // r0 is hardwired: never busy, never counts.
  assign busy_vec[0]    = 1'b0;
  assign busy_nxt[0]    = 1'b0;
  assign ovf_hit_vec[0] = 1'b0;
  assign cnt_arr[0]     = '0;

  // stall is derived only from state and sources, so acceptance cannot loop back into it.
  assign accepted = issue_valid && !stall && (issue_wa != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry u_entry (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (flush),
      .issue_hit_i  (accepted && (issue_wa == AW'(r))),
      .wb_hit_i     (wb_en && (wb_wa == AW'(r))),
      .issue_tnew_i (issue_tnew),
      .cnt_o        (cnt_arr[r]),
      .busy_o       (busy_vec[r]),
      .busy_nxt_o   (busy_nxt[r]),
      .ovf_hit_o    (ovf_hit_vec[r])
    );
  end

  // Source query: hazard when the result is still further away than the consumer can wait.
  always_comb begin
    hazard1 = (ra1 != '0) && busy_vec[ra1] && (cnt_arr[ra1] > tuse1);
    hazard2 = (ra2 != '0) && busy_vec[ra2] && (cnt_arr[ra2] > tuse2);
    stall   = hazard1 | hazard2;
    fwd1    = (ra1 != '0) && busy_vec[ra1] && !hazard1;
    fwd2    = (ra2 != '0) && busy_vec[ra2] && !hazard2;
  end

  // Popcount of next-state busy bits so busy_count tracks the entries on the same edge.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_count_d = busy_count_d + (AW+1)'(busy_nxt[i]);
    end
  end

  // busy_count register and sticky overflow; flush leaves ovf alone, only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_count_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      busy_count_q <= busy_count_d;
      if (|ovf_hit_vec) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign busy_count = busy_count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: per-cycle vector table plus a short multi-register sequence.
// Inputs are driven on the falling edge; outputs are checked 1 time unit later, before the next rising edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset, flush, issue_valid, wb_en;
  logic [4:0] issue_wa, ra1, ra2, wb_wa;
  logic [1:0] issue_tnew, tuse1, tuse2;
  logic       stall, fwd1, fwd2, ovf;
  logic [5:0] busy_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_wa   (issue_wa),
    .issue_tnew (issue_tnew),
    .ra1        (ra1),
    .ra2        (ra2),
    .tuse1      (tuse1),
    .tuse2      (tuse2),
    .wb_en      (wb_en),
    .wb_wa      (wb_wa),
    .stall      (stall),
    .fwd1       (fwd1),
    .fwd2       (fwd2),
    .busy_count (busy_count),
    .ovf        (ovf)
  );

  typedef struct {
    int rst_n, fl, iv, wa, tn, ra1, tu1, ra2, tu2, wbe, wbwa;
    int e_stall, e_f1, e_f2, e_bc, e_ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(int rst_n, int fl, int iv, int wa, int tn,
                              int ra1_v, int tu1, int ra2_v, int tu2, int wbe, int wbwa,
                              int e_stall, int e_f1, int e_f2, int e_bc, int e_ovf);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.wa = wa; v.tn = tn;
    v.ra1 = ra1_v; v.tu1 = tu1; v.ra2 = ra2_v; v.tu2 = tu2; v.wbe = wbe; v.wbwa = wbwa;
    v.e_stall = e_stall; v.e_f1 = e_f1; v.e_f2 = e_f2; v.e_bc = e_bc; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst_n[0];
    flush       = v.fl[0];
    issue_valid = v.iv[0];
    issue_wa    = v.wa[4:0];
    issue_tnew  = v.tn[1:0];
    ra1         = v.ra1[4:0];
    tuse1       = v.tu1[1:0];
    ra2         = v.ra2[4:0];
    tuse2       = v.tu2[1:0];
    wb_en       = v.wbe[0];
    wb_wa       = v.wbwa[4:0];
  endtask

  task automatic check_outs(input string tag, input int es, input int ef1, input int ef2,
                            input int ebc, input int eovf);
    chk({tag, " stall"},      int'(stall),      es);
    chk({tag, " fwd1"},       int'(fwd1),       ef1);
    chk({tag, " fwd2"},       int'(fwd2),       ef2);
    chk({tag, " busy_count"}, int'(busy_count), ebc);
    chk({tag, " ovf"},        int'(ovf),        eovf);
  endtask

  // Drive at the falling edge, check before the rising edge, then step one cycle.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    check_outs(tag, v.e_stall, v.e_f1, v.e_f2, v.e_bc, v.e_ovf);
    @(negedge clk);
  endtask

  initial begin
    //           rst fl iv wa tn  ra1 tu1 ra2 tu2 wbe wbwa   st f1 f2 bc ovf
    // load-use: tnew=2 against tuse=0 stalls two cycles, then forwards
    tbl[0]  = mk(1, 0, 1, 8, 2,   0, 0,   0, 0,   0, 0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0,   8, 0,   0, 0,   0, 0,    1, 0, 0, 1, 0);
    // issue while stalled must not be accepted (r7 stays idle)
    tbl[2]  = mk(1, 0, 1, 7, 1,   8, 0,   0, 0,   0, 0,    1, 0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0,   8, 0,   0, 0,   1, 8,    0, 1, 0, 1, 0);
    // ALU forward on rt, then wb retires r9
    tbl[4]  = mk(1, 0, 1, 9, 1,   8, 0,   0, 0,   0, 0,    0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0,   0, 0,   9, 1,   1, 9,    0, 0, 1, 1, 0);
    // WAW on r4: two writers, newest tnew=1 defines cnt
    tbl[6]  = mk(1, 0, 1, 4, 2,   0, 0,   9, 1,   0, 0,    0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 4, 1,   4, 2,   0, 0,   0, 0,    0, 1, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0,   4, 0,   0, 0,   1, 4,    1, 0, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0,   4, 0,   0, 0,   1, 4,    0, 1, 0, 1, 0);
    // r0: issue and wb to r0 are no-ops
    tbl[10] = mk(1, 0, 1, 0, 2,   4, 0,   0, 0,   0, 0,    0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 1, 5, 1,   0, 0,   0, 0,   1, 0,    0, 0, 0, 0, 0);
    // four issues to r5 without wb: the fourth overflows
    tbl[12] = mk(1, 0, 1, 5, 1,   0, 0,   0, 0,   0, 0,    0, 0, 0, 1, 0);
    tbl[13] = mk(1, 0, 1, 5, 1,   0, 0,   0, 0,   0, 0,    0, 0, 0, 1, 0);
    tbl[14] = mk(1, 0, 1, 5, 1,   0, 0,   0, 0,   0, 0,    0, 0, 0, 1, 0);
    // flush during stall: entries clear, ovf survives
    tbl[15] = mk(1, 1, 0, 0, 0,   5, 0,   0, 0,   0, 0,    1, 0, 0, 1, 1);
    tbl[16] = mk(1, 0, 1, 6, 2,   5, 0,   0, 0,   0, 0,    0, 0, 0, 0, 1);
    // simultaneous issue+wb on r6 (owners=1): owners stays 1, cnt reloads to 1
    tbl[17] = mk(1, 0, 1, 6, 1,   0, 0,   6, 2,   1, 6,    0, 0, 1, 1, 1);
    tbl[18] = mk(1, 1, 0, 0, 0,   0, 0,   6, 0,   0, 0,    1, 0, 0, 1, 1);
    tbl[19] = mk(1, 0, 0, 0, 0,   0, 0,   6, 0,   0, 0,    0, 0, 0, 0, 1);
    // reset clears the sticky overflow
    tbl[20] = mk(0, 0, 0, 0, 0,   0, 0,   0, 0,   0, 0,    0, 0, 0, 0, 1);
    tbl[21] = mk(1, 0, 0, 0, 0,   0, 0,   0, 0,   0, 0,    0, 0, 0, 0, 0);

    // Reset: hold low across two rising edges, release, check idle outputs.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // Several registers in flight at once, staggered countdowns, plus a stray wb.
    step(mk(1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "seqA");
    step(mk(1, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0), "seqB");
    step(mk(1, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0), "seqC");
    // r12 cnt=1 vs tuse 0 stalls; r11 has counted down to 0 and forwards
    step(mk(1, 0, 0, 0, 0, 12, 0, 11, 0, 1, 13, 1, 0, 1, 3, 0), "seqD");
    // wb to idle r13 was dropped; r12 now forwards
    step(mk(1, 0, 0, 0, 0, 12, 0, 0, 0, 1, 10,  0, 1, 0, 3, 0), "seqE");
    drive(mk(1, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    #1;
    check_outs("seqF", 0, 0, 0, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
